// File: rtl/btn_led_pkg.sv
// btn_led_pkg: types and constants shared by the push-button front end
// (btn_led_div) and the LED counter it drives (led_cnt).
//   DIV_W       - width of the led_cnt divider interface
//   btn_state_t - press-classifier FSM states; REPEAT exists only when
//                 BTN_AUTOREPEAT_EN is defined
package btn_led_pkg;

    localparam int DIV_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        HELD,
        SHORT_WR,
        LONG_WR,
        WAIT_REL
`ifdef BTN_AUTOREPEAT_EN
        , REPEAT
`endif
    } btn_state_t;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, polarity normalisation and debouncer for
// one raw push-button.
//   clk     in   system clock
//   rstn    in   synchronous active-low reset
//   btn_i   in   raw asynchronous button
//   level_o out  debounced level, active-high (1 = pressed)
//   rise_o  out  one-cycle pulse in the first cycle level_o reads 1
//   fall_o  out  one-cycle pulse in the first cycle level_o reads 0
// A raw edge shows up on level_o DEBOUNCE_CYCLES+2 cycles later (two
// synchroniser stages plus DEBOUNCE_CYCLES cycles of stable disagreement).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int   CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LIM = CW'(DEBOUNCE_CYCLES - 1);
    // Raw level of a released button; also the synchroniser reset value so
    // reset never looks like a press.
    localparam logic RAW_IDLE = (BTN_ACTIVE_LOW != 0);

    logic          sync1, sync2;
    logic          norm;
    logic [CW-1:0] cnt;

    assign norm = sync2 ^ RAW_IDLE;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1   <= RAW_IDLE;
            sync2   <= RAW_IDLE;
            cnt     <= '0;
            level_o <= 1'b0;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
        end else begin
            sync1  <= btn_i;
            sync2  <= sync1;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            if (norm == level_o) begin
                cnt <= '0;
            end else if (cnt == CNT_LIM) begin
                // DEBOUNCE_CYCLES consecutive disagreeing cycles: accept.
                // Flipping resets the counter, so it never passes CNT_LIM.
                level_o <= norm;
                rise_o  <= norm;
                fall_o  <= ~norm;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_led_div.sv
// btn_led_div: push-button front end that writes the led_cnt blink-rate
// interface. Debounced presses are classified as short or long; a short
// press steps the divider up (wrapping DIV_MAX -> 0), a long press restores
// DIV_DEFAULT. Each write is a registered div_o with a one-cycle wren_o on
// the same edge.
//   clk100    in   system clock (100 MHz)
//   rstn      in   synchronous active-low reset
//   btn_i     in   raw asynchronous push-button
//   div_o     out  divider value for led_cnt div_i
//   wren_o    out  one-cycle write strobe for led_cnt wren_i
//   pressed_o out  debounced pressed level, active-high
// Optional: define BTN_AUTOREPEAT_EN to make a long press step the divider
// and keep stepping every REPEAT_CYCLES until release.
module btn_led_div #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int REPEAT_CYCLES   = 25_000_000,
    parameter int DIV_W           = btn_led_pkg::DIV_W,
    parameter int DIV_DEFAULT     = 2,
    parameter int DIV_MAX         = 31,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic             clk100,
    input  logic             rstn,
    input  logic             btn_i,
    output logic [DIV_W-1:0] div_o,
    output logic             wren_o,
    output logic             pressed_o
);

    localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [HW-1:0]    HOLD_LIM = HW'(LONG_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_DEF  = DIV_W'(DIV_DEFAULT);
    localparam logic [DIV_W-1:0] DIV_TOP  = DIV_W'(DIV_MAX);

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("btn_led_div: cycle-count parameters out of range");
    end

    function automatic logic [DIV_W-1:0] div_step(input logic [DIV_W-1:0] d);
        return (d == DIV_TOP) ? '0 : d + 1'b1;
    endfunction

    logic level, rise, fall;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_deb (
        .clk     (clk100),
        .rstn    (rstn),
        .btn_i   (btn_i),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    assign pressed_o = level;

    btn_led_pkg::btn_state_t state;
    logic [HW-1:0]           hold_cnt;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REP_LIM = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rep_cnt;
`endif

    always_ff @(posedge clk100) begin
        if (!rstn) begin
            state    <= btn_led_pkg::IDLE;
            hold_cnt <= '0;
            div_o    <= DIV_DEF;
            wren_o   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt  <= '0;
`endif
        end else begin
            wren_o <= 1'b0;
            case (state)
                btn_led_pkg::IDLE: begin
                    if (rise) begin
                        state    <= btn_led_pkg::HELD;
                        hold_cnt <= '0;
                    end
                end
                btn_led_pkg::HELD: begin
                    // Release is tested first so it wins a tie with the
                    // threshold. The fall pulse cannot be missed here: HELD
                    // is entered right after rise and lasts until release.
                    if (fall) begin
                        state <= btn_led_pkg::SHORT_WR;
                    end else if (hold_cnt == HOLD_LIM) begin
                        state <= btn_led_pkg::LONG_WR;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                btn_led_pkg::SHORT_WR: begin
                    div_o  <= div_step(div_o);
                    wren_o <= 1'b1;
                    state  <= btn_led_pkg::IDLE;
                end
                btn_led_pkg::LONG_WR: begin
                    wren_o <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                    div_o   <= div_step(div_o);
                    rep_cnt <= '0;
                    state   <= btn_led_pkg::REPEAT;
`else
                    div_o <= DIV_DEF;
                    state <= btn_led_pkg::WAIT_REL;
`endif
                end
                // The release may land while LONG_WR is writing, so the
                // states after it watch the level rather than the fall pulse.
                btn_led_pkg::WAIT_REL: begin
                    if (!level) state <= btn_led_pkg::IDLE;
                end
`ifdef BTN_AUTOREPEAT_EN
                btn_led_pkg::REPEAT: begin
                    if (!level) begin
                        state <= btn_led_pkg::IDLE;
                    end else if (rep_cnt == REP_LIM) begin
                        div_o   <= div_step(div_o);
                        wren_o  <= 1'b1;
                        rep_cnt <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                end
`endif
                default: state <= btn_led_pkg::IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_led_div.sv
// Directed bench for btn_led_div with small timing parameters. Every press
// pushes its expected write(s) {cycle, divider} into a queue; a monitor pops
// one entry per wren_o pulse and compares. Build with +define+BTN_AUTOREPEAT_EN
// to exercise the auto-repeat long press.
module tb_btn_led_div;

    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;
    localparam int LAT  = DEB + 2;

    typedef struct {
        int cyc;
        int div;
    } exp_t;

    logic       clk100 = 1'b0;
    logic       rstn   = 1'b0;
    logic       btn_i  = 1'b1;
    logic [4:0] div_o;
    logic       wren_o;
    logic       pressed_o;

    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    int   exp_div = 2;
    exp_t q[$];

    btn_led_div #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG),
        .REPEAT_CYCLES   (REP),
        .DIV_W           (5),
        .DIV_DEFAULT     (2),
        .DIV_MAX         (31),
        .BTN_ACTIVE_LOW  (1)
    ) dut (
        .clk100    (clk100),
        .rstn      (rstn),
        .btn_i     (btn_i),
        .div_o     (div_o),
        .wren_o    (wren_o),
        .pressed_o (pressed_o)
    );

    always #5 clk100 = ~clk100;
    always @(posedge clk100) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int step(input int d);
        return (d == 31) ? 0 : d + 1;
    endfunction

    // Scoreboard side: every strobe must match the oldest expected write.
    always @(negedge clk100) begin
        if (wren_o === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_wren", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wren_cycle", 32'(cyc), 32'(e.cyc));
                chk("wren_div", 32'(div_o), 32'(e.div));
            end
        end
    end

    // Wait (bounded) for all expected writes, then idle long enough for any
    // stray strobe to reach the monitor.
    task automatic drain(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk100);
        chk("drain_empty", 32'(q.size()), 32'd0);
        repeat (12) @(negedge clk100);
    endtask

    task automatic short_press(input int n);
        int t0;
        t0      = cyc;
        btn_i   = 1'b0;
        exp_div = step(exp_div);
        q.push_back('{t0 + n + LAT + 2, exp_div});
        repeat (n) @(negedge clk100);
        btn_i = 1'b1;
        drain(40);
    endtask

    initial begin
        int t0, t1;
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1;
        repeat (3) @(negedge clk100);
        chk("reset_div", 32'(div_o), 32'd2);
        chk("reset_wren", 32'(wren_o), 32'd0);
        chk("reset_pressed", 32'(pressed_o), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk100);

        // 3-cycle glitch: no level change, and the monitor sees no strobe.
        btn_i = 1'b0;
        repeat (3) @(negedge clk100);
        btn_i = 1'b1;
        t1 = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk100);
            if (pressed_o !== 1'b0) t1++;
        end
        chk("glitch_pressed", 32'(t1), 32'd0);

        // First short press (10 cycles) with exact debounce latency checks.
        t0      = cyc;
        btn_i   = 1'b0;
        exp_div = step(exp_div);
        q.push_back('{t0 + 10 + LAT + 2, exp_div});
        repeat (LAT - 1) @(negedge clk100);
        chk("rise_before", 32'(pressed_o), 32'd0);
        @(negedge clk100);
        chk("rise_at", 32'(pressed_o), 32'd1);
        repeat (10 - LAT) @(negedge clk100);
        btn_i = 1'b1;
        repeat (LAT - 1) @(negedge clk100);
        chk("fall_before", 32'(pressed_o), 32'd1);
        @(negedge clk100);
        chk("fall_at", 32'(pressed_o), 32'd0);
        drain(40);
        chk("div_after_first", 32'(div_o), 32'd3);

        // Step up to DIV_MAX, then one more press wraps to 0, then on to 5.
        while (exp_div != 31) short_press(5);
        chk("div_at_max", 32'(div_o), 32'd31);
        short_press(5);
        chk("div_wrapped", 32'(div_o), 32'd0);
        while (exp_div != 5) short_press(5);

        // Long press. Threshold is reached LAT+1+(LONG-1) cycles after the
        // raw edge; the write lands 2 cycles later.
        t0    = cyc;
        btn_i = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        for (int k = 0; k < 3; k++) begin
            exp_div = step(exp_div);
            q.push_back('{t0 + LAT + LONG + 2 + k * REP, exp_div});
        end
        repeat (40) @(negedge clk100);
`else
        exp_div = 2;
        q.push_back('{t0 + LAT + LONG + 2, exp_div});
        repeat (30) @(negedge clk100);
`endif
        btn_i = 1'b1;
        drain(60);
        chk("div_after_long", 32'(div_o), 32'(exp_div));

        // Move away from the default so the reset is visible on div_o.
        short_press(5);

        // Reset while HELD with the button still down.
        btn_i = 1'b0;
        repeat (LAT + 4) @(negedge clk100);
        rstn = 1'b0;
        repeat (2) @(negedge clk100);
        chk("midreset_div", 32'(div_o), 32'd2);
        chk("midreset_wren", 32'(wren_o), 32'd0);
        chk("midreset_pressed", 32'(pressed_o), 32'd0);
        exp_div = 2;
        t1      = cyc;
        rstn    = 1'b1;
        repeat (LAT - 1) @(negedge clk100);
        chk("repress_before", 32'(pressed_o), 32'd0);
        @(negedge clk100);
        chk("repress_at", 32'(pressed_o), 32'd1);
        repeat (2) @(negedge clk100);
        exp_div = step(exp_div);
        q.push_back('{t1 + LAT + 2 + LAT + 2, exp_div});
        btn_i = 1'b1;
        drain(40);
        chk("div_after_reset_press", 32'(div_o), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
